stream_program_loader: RTL and testbench

Serial-stream program loader that sits directly upstream of the system RAM and fills it with a program image before the CPU runs. It accepts a framed byte stream over a valid/ready handshake, assembles bytes into words, writes them to consecutive RAM addresses from 0, and checks a trailing XOR checksum. It raises `load_complete`, or `load_error` on failure, toward the system control state machine.

---
 rtl/stream_program_loader_pkg.sv | 21 ++
 rtl/stream_program_loader_word_assembler.sv | 68 ++++++
 rtl/stream_program_loader.sv | 136 +++++++++++++
 tb/tb_stream_program_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_program_loader_pkg.sv
// Shared types and constants for the stream program loader.
package stream_program_loader_pkg;

  localparam int LEN_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_e;

  function automatic int bytes_per_word(input int word_size);
    return (word_size + 7) / 8;
  endfunction

endpackage

// File: rtl/stream_program_loader_word_assembler.sv
// Byte-to-word assembler with payload byte counter and running XOR.
import stream_program_loader_pkg::*;

module word_assembler #(
  parameter int WORD_SIZE = 16,
  parameter int BPW       = bytes_per_word(WORD_SIZE)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 byte_en_i,
  input  logic [7:0]           byte_i,
  output logic [WORD_SIZE-1:0] word_next_o,
  output logic                 last_byte_o,
  output logic [7:0]           xor_o
);

  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       xor_q, xor_d;

  assign last_byte_o = (cnt_q == CNT_W'(BPW - 1));
  assign xor_o       = xor_q;

  // Only the low WORD_SIZE-8 bits survive into the next word; older bits drop off the top.
  if (WORD_SIZE > 8) begin : g_wide
    logic [WORD_SIZE-9:0] shift_q, shift_d;

    assign word_next_o = {shift_q, byte_i};

    always_comb begin
      shift_d = shift_q;
      if (clear_i)        shift_d = '0;
      else if (byte_en_i) shift_d = word_next_o[WORD_SIZE-9:0];
    end

    always_ff @(posedge clock) begin
      if (reset) shift_q <= '0;
      else       shift_q <= shift_d;
    end
  end else begin : g_narrow
    assign word_next_o = byte_i[WORD_SIZE-1:0];
  end

  always_comb begin
    cnt_d = cnt_q;
    xor_d = xor_q;
    if (clear_i) begin
      cnt_d = '0;
      xor_d = '0;
    end else if (byte_en_i) begin
      cnt_d = last_byte_o ? '0 : CNT_W'(cnt_q + 1'b1);
      xor_d = xor_q ^ byte_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      xor_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      xor_q <= xor_d;
    end
  end

endmodule

// File: rtl/stream_program_loader.sv
// Framed byte-stream loader: fills RAM from address 0 and verifies a trailing XOR checksum.
//   state  | meaning
//   IDLE   | waiting for start_load
//   LEN_HI | expecting word-count high byte
//   LEN_LO | expecting word-count low byte, range check
//   DATA   | collecting payload bytes of a word
//   WRITE  | one-cycle RAM write strobe
//   CSUM   | expecting checksum byte
//   DONE   | image good, hold load_complete until start_load drops
//   ERROR  | length/checksum failure, held until reset
import stream_program_loader_pkg::*;

module stream_program_loader #(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_ADDR_SIZE = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start_load,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]     mem_write_data,
  output logic                     mem_write,
  output logic                     load_complete,
  output logic                     load_error
);

  localparam int          IDX_W     = MEM_ADDR_SIZE + 1;
  localparam int unsigned MAX_WORDS = 1 << MEM_ADDR_SIZE;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic                   ready_q, wr_q, done_q, err_q;

  logic                   hs, asm_clear, asm_en, last_byte;
  logic [WORD_SIZE-1:0]   word_next;
  logic [7:0]             xor_sum;
  logic [LEN_WIDTH-1:0]   len_new;

  assign hs        = in_valid && ready_q;
  assign asm_clear = (state_q == ST_IDLE) && start_load;
  assign asm_en    = (state_q == ST_DATA) && hs;
  assign len_new   = {len_q[LEN_WIDTH-1:8], in_data};

  word_assembler #(.WORD_SIZE(WORD_SIZE)) u_asm (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (asm_clear),
    .byte_en_i   (asm_en),
    .byte_i      (in_data),
    .word_next_o (word_next),
    .last_byte_o (last_byte),
    .xor_o       (xor_sum)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: if (start_load) begin
        state_d = ST_LEN_HI;
        idx_d   = '0;
      end
      ST_LEN_HI:
        if (!start_load) state_d = ST_IDLE;
        else if (hs) begin
          len_d[LEN_WIDTH-1:8] = in_data;
          state_d = ST_LEN_LO;
        end
      ST_LEN_LO:
        if (!start_load) state_d = ST_IDLE;
        else if (hs) begin
          len_d = len_new;
          if (32'(len_new) > MAX_WORDS) state_d = ST_ERROR;
          else if (len_new == '0)       state_d = ST_CSUM;
          else                          state_d = ST_DATA;
        end
      ST_DATA:
        if (!start_load) state_d = ST_IDLE;
        else if (hs && last_byte) begin
          wdata_d = word_next;
          state_d = ST_WRITE;
        end
      ST_WRITE:
        if (!start_load) state_d = ST_IDLE;
        else begin
          idx_d   = IDX_W'(idx_q + 1'b1);
          state_d = ((LEN_WIDTH'(idx_q) + 1'b1) == len_q) ? ST_CSUM : ST_DATA;
        end
      ST_CSUM:
        if (!start_load) state_d = ST_IDLE;
        else if (hs) state_d = (in_data == xor_sum) ? ST_DONE : ST_ERROR;
      ST_DONE:  if (!start_load) state_d = ST_IDLE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      // Status outputs are registered copies of the next state.
      ready_q <= (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                 (state_d == ST_DATA)   || (state_d == ST_CSUM);
      wr_q    <= (state_d == ST_WRITE);
      done_q  <= (state_d == ST_DONE);
      err_q   <= (state_d == ST_ERROR);
    end
  end

  assign in_ready       = ready_q;
  assign mem_write      = wr_q;
  assign mem_addr       = idx_q[MEM_ADDR_SIZE-1:0];
  assign mem_write_data = wdata_q;
  assign load_complete  = done_q;
  assign load_error     = err_q;

endmodule

// File: tb/tb_stream_program_loader.sv
// Directed bench for stream_program_loader (WORD_SIZE=16, MEM_ADDR_SIZE=8).
module tb_stream_program_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_load = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [7:0]  mem_addr;
  logic [15:0] mem_write_data;
  logic        mem_write;
  logic        load_complete;
  logic        load_error;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  wa_q[$];
  logic [15:0] wd_q[$];
  logic [15:0] exp_w[256];

  stream_program_loader #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .start_load     (start_load),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .load_complete  (load_complete),
    .load_error     (load_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record every write strobe cycle; a stretched strobe shows up as a duplicate entry.
  always @(negedge clock) begin
    if (mem_write) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_write_data);
      chk("ready_in_write", {31'b0, in_ready}, 32'd0);
    end
    if (load_complete || load_error)
      chk("done_err_excl", {31'b0, load_complete && load_error}, 32'd0);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    if (!in_ready) chk("hs_timeout", 32'd0, 32'd1);
    else tick();
    in_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int max_gap);
    return (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
  endfunction

  task automatic send_frame(input int n, input int max_gap, input bit bad);
    logic [15:0] len;
    logic [15:0] w;
    logic [7:0]  x;
    len = 16'(n);
    x   = 8'h00;
    send_byte(len[15:8], pick_gap(max_gap));
    send_byte(len[7:0], pick_gap(max_gap));
    for (int i = 0; i < n; i++) begin
      w = exp_w[i];
      send_byte(w[15:8], pick_gap(max_gap));
      send_byte(w[7:0], pick_gap(max_gap));
      x = x ^ w[15:8] ^ w[7:0];
    end
    send_byte(bad ? (x ^ 8'h01) : x, pick_gap(max_gap));
  endtask

  task automatic check_writes(input string tag, input int n);
    chk({tag, "_nwr"}, wa_q.size(), n);
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      chk({tag, "_addr"}, wa_q[i], i[7:0]);
      chk({tag, "_data"}, wd_q[i], exp_w[i]);
    end
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic nominal_words();
    exp_w[0] = 16'h1234;
    exp_w[1] = 16'hABCD;
    exp_w[2] = 16'h00FF;
  endtask

  task automatic end_frame(input string tag);
    start_load = 1'b0;
    tick();
    chk({tag, "_done_drop"}, {31'b0, load_complete}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_ready", {31'b0, in_ready}, 0);
    chk("rst_wr",    {31'b0, mem_write}, 0);
    chk("rst_addr",  {24'b0, mem_addr}, 0);
    chk("rst_wdata", {16'b0, mem_write_data}, 0);
    chk("rst_done",  {31'b0, load_complete}, 0);
    chk("rst_err",   {31'b0, load_error}, 0);
    reset = 1'b0;
    tick();

    // Nominal frame, in_valid held high
    nominal_words();
    start_load = 1'b1;
    send_frame(3, 0, 1'b0);
    chk("nom_done", {31'b0, load_complete}, 1);
    chk("nom_err",  {31'b0, load_error}, 0);
    chk("nom_hold", {16'b0, mem_write_data}, 32'h00FF);
    check_writes("nom", 3);
    tick();
    chk("nom_done_stays", {31'b0, load_complete}, 1);
    end_frame("nom");

    // Bad checksum
    start_load = 1'b1;
    send_frame(3, 0, 1'b1);
    chk("bad_err",  {31'b0, load_error}, 1);
    chk("bad_done", {31'b0, load_complete}, 0);
    check_writes("bad", 3);
    start_load = 1'b0;
    in_valid = 1'b1;
    repeat (4) tick();
    chk("bad_err_sticky", {31'b0, load_error}, 1);
    chk("bad_ready",      {31'b0, in_ready}, 0);
    in_valid = 1'b0;
    do_reset();
    chk("err_rst_clear", {31'b0, load_error}, 0);

    // Oversize length 0x0101
    start_load = 1'b1;
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk("len257_err",   {31'b0, load_error}, 1);
    chk("len257_ready", {31'b0, in_ready}, 0);
    check_writes("len257", 0);
    start_load = 1'b0;
    do_reset();

    // Full 256-word image
    for (int i = 0; i < 256; i++) exp_w[i] = {8'(i), 8'(i * 3 + 7)};
    start_load = 1'b1;
    send_frame(256, 0, 1'b0);
    chk("len256_done", {31'b0, load_complete}, 1);
    check_writes("len256", 256);
    end_frame("len256");

    // Empty image
    start_load = 1'b1;
    send_frame(0, 0, 1'b0);
    chk("len0_done", {31'b0, load_complete}, 1);
    check_writes("len0", 0);
    end_frame("len0");

    // Bubbles on in_valid
    nominal_words();
    start_load = 1'b1;
    send_frame(3, 3, 1'b0);
    chk("bub_done", {31'b0, load_complete}, 1);
    check_writes("bub", 3);
    end_frame("bub");

    // Abort after the first word
    start_load = 1'b1;
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    start_load = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hAB;
    repeat (5) tick();
    chk("abort_ready", {31'b0, in_ready}, 0);
    chk("abort_done",  {31'b0, load_complete}, 0);
    in_valid = 1'b0;
    check_writes("abort", 1);

    // Restart: addresses begin at 0 again
    start_load = 1'b1;
    send_frame(3, 0, 1'b0);
    chk("restart_done", {31'b0, load_complete}, 1);
    check_writes("restart", 3);
    end_frame("restart");

    // Reset in the middle of DATA
    start_load = 1'b1;
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h12, 0);
    in_valid = 1'b1;
    in_data  = 8'h34;
    reset = 1'b1;
    tick();
    chk("mid_rst_ready", {31'b0, in_ready}, 0);
    chk("mid_rst_wr",    {31'b0, mem_write}, 0);
    chk("mid_rst_addr",  {24'b0, mem_addr}, 0);
    chk("mid_rst_wdata", {16'b0, mem_write_data}, 0);
    chk("mid_rst_done",  {31'b0, load_complete}, 0);
    chk("mid_rst_err",   {31'b0, load_error}, 0);
    reset = 1'b0;
    start_load = 1'b0;
    in_valid = 1'b0;
    tick();
    check_writes("mid_rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
